// File: rtl/edge_pulse.sv
// rtl/edge_pulse.sv - level-to-pulse edge detector with optional synchronizer and debounce (PULSE_DEBOUNCE_EN)
module edge_pulse #(
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_MODE       = 0,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  // Out-of-range configuration stops elaboration.
  if (SYNC_STAGES < 0 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("edge_pulse: SYNC_STAGES must be 0..4");
  end
  if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
    $error("edge_pulse: EDGE_MODE must be 0..2");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 1023) begin : g_bad_db
    $error("edge_pulse: DEBOUNCE_CYCLES must be 1..1023");
  end

  logic level;       // synchronized level L
  logic edge_level;  // level fed to history and edge logic (L, or filtered F)

  if (SYNC_STAGES == 0) begin : g_nosync
    assign level = in;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift chain: stage 0 samples in, each later stage takes the previous one.
    always_comb begin
      sync_d[0] = in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_d[i] = sync_q[i-1];
      end
    end

    // Synchronizer flops, cleared by reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        sync_q <= '0;
      end else begin
        sync_q <= sync_d;
      end
    end

    assign level = sync_q[SYNC_STAGES-1];
  end

`ifdef PULSE_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             filt_q;
  logic             filt_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Filter adopts the level once it has disagreed for DEBOUNCE_CYCLES consecutive clocks.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (level != filt_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = level;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign edge_level = filt_q;
`else
  assign edge_level = level;
`endif

  logic hist_q;
  logic hist_d;
  logic out_q;
  logic out_d;

  // Edge decode against the previous cycle's level.
  always_comb begin
    hist_d = edge_level;
    out_d  = 1'b0;
    case (EDGE_MODE)
      0:       out_d = edge_level & ~hist_q;
      1:       out_d = ~edge_level & hist_q;
      default: out_d = edge_level ^ hist_q;
    endcase
  end

  // History and output registers; reset wins over any pulse in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= 1'b0;
      out_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_edge_pulse.sv
// tb/tb_edge_pulse.sv - randomized self-checking bench for edge_pulse against a history-based model
module tb_edge_pulse;

  localparam int NI   = 6;
  localparam int MAXN = 4096;
  localparam int DB   = 4;
  localparam int SY [NI] = '{2, 0, 0, 0, 3, 1};
  localparam int MD [NI] = '{0, 1, 2, 0, 2, 1};

  logic          clk;
  logic          reset;
  logic          in;
  logic [NI-1:0] dut_out;

  int checks;
  int errors;
  int n;
  int pulse_cnt;

  bit in_h  [MAXN];
  bit rst_h [MAXN];
  bit e_h   [NI][MAXN];
  bit exp_out [NI];
`ifdef PULSE_DEBOUNCE_EN
  bit fst [NI];
  int run [NI];
`endif

  edge_pulse #(.SYNC_STAGES(2), .EDGE_MODE(0), .DEBOUNCE_CYCLES(DB)) u_r2 (.clk(clk), .reset(reset), .in(in), .out(dut_out[0]));
  edge_pulse #(.SYNC_STAGES(0), .EDGE_MODE(1), .DEBOUNCE_CYCLES(DB)) u_f0 (.clk(clk), .reset(reset), .in(in), .out(dut_out[1]));
  edge_pulse #(.SYNC_STAGES(0), .EDGE_MODE(2), .DEBOUNCE_CYCLES(DB)) u_b0 (.clk(clk), .reset(reset), .in(in), .out(dut_out[2]));
  edge_pulse #(.SYNC_STAGES(0), .EDGE_MODE(0), .DEBOUNCE_CYCLES(DB)) u_r0 (.clk(clk), .reset(reset), .in(in), .out(dut_out[3]));
  edge_pulse #(.SYNC_STAGES(3), .EDGE_MODE(2), .DEBOUNCE_CYCLES(DB)) u_b3 (.clk(clk), .reset(reset), .in(in), .out(dut_out[4]));
  edge_pulse #(.SYNC_STAGES(1), .EDGE_MODE(1), .DEBOUNCE_CYCLES(DB)) u_f1 (.clk(clk), .reset(reset), .in(in), .out(dut_out[5]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Level seen by the edge logic at edge e: the input sampled s edges earlier,
  // forced to 0 if any reset edge fell inside that window.
  function automatic bit level_at(input int e, input int s);
    if (e - s < 0) return 1'b0;
    for (int j = e - s; j < e; j++) begin
      if (rst_h[j]) return 1'b0;
    end
    return in_h[e - s];
  endfunction

  task automatic step(input bit r, input bit v);
    @(negedge clk);
    reset = r;
    in    = v;
    @(posedge clk);
    in_h[n]  = v;
    rst_h[n] = r;
    for (int i = 0; i < NI; i++) begin
      bit lv;
      bit ev;
      bit hv;
      bit ov;
      lv = level_at(n, SY[i]);
`ifdef PULSE_DEBOUNCE_EN
      ev = fst[i];
      if (r) begin
        fst[i] = 1'b0;
        run[i] = 0;
      end else if (lv != fst[i]) begin
        run[i]++;
        if (run[i] == DB) begin
          fst[i] = lv;
          run[i] = 0;
        end
      end else begin
        run[i] = 0;
      end
`else
      ev = lv;
`endif
      e_h[i][n] = ev;
      hv = (n == 0 || rst_h[n-1]) ? 1'b0 : e_h[i][n-1];
      case (MD[i])
        0:       ov = ev & ~hv;
        1:       ov = ~ev & hv;
        default: ov = ev ^ hv;
      endcase
      exp_out[i] = r ? 1'b0 : ov;
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("out%0d_c%0d", i, n), dut_out[i], exp_out[i]);
    end
    if (dut_out[0] === 1'b1) pulse_cnt++;
    n++;
  endtask

  initial begin
    bit rv;
    bit lv;
    int hold;
    checks    = 0;
    errors    = 0;
    n         = 0;
    pulse_cnt = 0;
    reset     = 1'b1;
    in        = 1'b0;
`ifdef PULSE_DEBOUNCE_EN
    for (int i = 0; i < NI; i++) begin
      fst[i] = 1'b0;
      run[i] = 0;
    end
`endif

    // Reset, then quiet input.
    step(1'b1, 1'b0);
    check("rst_state", dut_out, '0);
    for (int c = 0; c < 5; c++) step(1'b0, 1'b0);

    // 100 held pulses on the default instance feed a downstream counter.
    pulse_cnt = 0;
    for (int rep = 0; rep < 100; rep++) begin
      for (int c = 0; c < 5; c++) step(1'b0, 1'b1);
      for (int c = 0; c < 5; c++) step(1'b0, 1'b0);
    end
    check("count100", pulse_cnt, 100);

    // Toggle every cycle.
    for (int c = 0; c < 20; c++) step(1'b0, c[0]);
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0);

    // Input high throughout reset.
    for (int c = 0; c < 3; c++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
`ifndef PULSE_DEBOUNCE_EN
    check("rstrel_r0_first", dut_out[3], 1);
    check("rstrel_f0_first", dut_out[1], 0);
`endif
    step(1'b0, 1'b1);
`ifndef PULSE_DEBOUNCE_EN
    check("rstrel_r0_second", dut_out[3], 0);
`endif
    step(1'b0, 1'b1);
`ifndef PULSE_DEBOUNCE_EN
    check("rstrel_r2_third", dut_out[0], 1);
`endif
    for (int c = 0; c < 8; c++) step(1'b0, 1'b1);
    for (int c = 0; c < 8; c++) step(1'b0, 1'b0);

    // Reset lands on the edge where the default instance would pulse.
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("rst_kills_pulse", dut_out[0], 0);
    pulse_cnt = 0;
    for (int c = 0; c < 8; c++) step(1'b0, 1'b0);
    check("no_pulse_after_rst", pulse_cnt, 0);

    // Random levels with random hold times and occasional reset.
    for (int b = 0; b < 300; b++) begin
      lv   = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 8);
      for (int j = 0; j < hold; j++) begin
        rv = ($urandom_range(0, 99) == 0);
        step(rv, lv);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
